// File: rtl/jpeg_out_pkg.sv
// ============================================================================
// Module      : jpeg_out_pkg
// Description : Shared pixel/block types, read-FSM states and output packing
//               for the RGB block serializer (SERIALIZER_RGB565_EN selects
//               16-bit RGB565 output packing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jpeg_out_pkg;

    localparam int PIX_W = 8;

`ifdef SERIALIZER_RGB565_EN
    localparam int PIX_OUT_W = 16;
`else
    localparam int PIX_OUT_W = 3 * PIX_W;
`endif

    typedef struct packed {
        logic [PIX_W-1:0] r;
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
    } rgb_pixel_t;

    typedef rgb_pixel_t [7:0][7:0] rgb_block_t;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } rd_state_t;

    function automatic logic [PIX_OUT_W-1:0] pack_pixel(input rgb_pixel_t p);
`ifdef SERIALIZER_RGB565_EN
        // Plain truncation of the low bits, no rounding.
        return {p.r[PIX_W-1 -: 5], p.g[PIX_W-1 -: 6], p.b[PIX_W-1 -: 5]};
`else
        return {p.r, p.g, p.b};
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_pingpong_buf.sv
// ============================================================================
// Module      : rgb_pingpong_buf
// Description : Two full 8x8 RGB block registers; whole-block write port and
//               single-pixel read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_pingpong_buf
    import jpeg_out_pkg::*;
(
    input  logic       clk,
    input  logic       i_wr_en,
    input  logic       i_wr_sel,
    input  rgb_block_t i_blk,
    input  logic       i_rd_sel,
    input  logic [2:0] i_row,
    input  logic [2:0] i_col,
    output rgb_pixel_t o_pix
);

    // Data storage only; occupancy is tracked by the controller, so no reset.
    rgb_block_t r_buf [2];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_buf[i_wr_sel] <= i_blk;
        end
    end

    assign o_pix = r_buf[i_rd_sel][i_row][i_col];

endmodule

`default_nettype wire

// File: rtl/rgb_block_serializer.sv
// ============================================================================
// Module      : rgb_block_serializer
// Description : Captures 8x8 RGB blocks into a ping-pong buffer and streams
//               them one pixel per cycle in raster order over valid/ready.
//               Optional macro SERIALIZER_RGB565_EN: 16-bit RGB565 pix_out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_block_serializer
    import jpeg_out_pkg::*;
#(
    parameter int NBUF = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic [7:0][7:0][PIX_W-1:0]  r_in,
    input  logic [7:0][7:0][PIX_W-1:0]  g_in,
    input  logic [7:0][7:0][PIX_W-1:0]  b_in,
    output logic                        in_ready,
    output logic [PIX_OUT_W-1:0]        pix_out,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic [2:0]                  pix_row,
    output logic [2:0]                  pix_col,
    output logic                        block_last,
    output logic                        overflow
);

    localparam logic [1:0] C_NBUF = 2'(NBUF);

    rd_state_t  r_state;
    logic       r_wr_sel;
    logic       r_rd_sel;
    logic [1:0] r_count;
    logic [2:0] r_row;
    logic [2:0] r_col;
    logic       r_overflow;
    logic       r_in_ready;

    rgb_block_t w_blk;
    rgb_pixel_t w_pix;
    logic       w_xfer;
    logic       w_pop;
    logic       w_cap;
    logic       w_drop;
    logic [1:0] w_count_nxt;

    always_comb begin
        w_blk = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                w_blk[i][j] = '{r: r_in[i][j], g: g_in[i][j], b: b_in[i][j]};
            end
        end
    end

    // A final-pixel pop frees a slot in the same cycle, so a full buffer
    // still accepts a block arriving on that cycle.
    assign w_xfer      = (r_state == ST_STREAM) && pix_ready;
    assign w_pop       = w_xfer && (r_row == 3'd7) && (r_col == 3'd7);
    assign w_cap       = valid_in && ((r_count < C_NBUF) || w_pop);
    assign w_drop      = valid_in && !w_cap;
    assign w_count_nxt = r_count + {1'b0, w_cap} - {1'b0, w_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_wr_sel   <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_count    <= 2'd0;
            r_row      <= 3'd0;
            r_col      <= 3'd0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_cap) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt < C_NBUF);

            case (r_state)
                ST_IDLE: begin
                    r_row <= 3'd0;
                    r_col <= 3'd0;
                    if (r_count != 2'd0) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_rd_sel <= ~r_rd_sel;
                        r_row    <= 3'd0;
                        r_col    <= 3'd0;
                        if (w_count_nxt == 2'd0) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_xfer) begin
                        if (r_col == 3'd7) begin
                            r_col <= 3'd0;
                            r_row <= r_row + 3'd1;
                        end else begin
                            r_col <= r_col + 3'd1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    rgb_pingpong_buf u_buf (
        .clk      (clk),
        .i_wr_en  (w_cap),
        .i_wr_sel (r_wr_sel),
        .i_blk    (w_blk),
        .i_rd_sel (r_rd_sel),
        .i_row    (r_row),
        .i_col    (r_col),
        .o_pix    (w_pix)
    );

    assign pix_valid  = (r_state == ST_STREAM);
    assign pix_out    = pix_valid ? pack_pixel(w_pix) : '0;
    assign pix_row    = r_row;
    assign pix_col    = r_col;
    assign block_last = pix_valid && (r_row == 3'd7) && (r_col == 3'd7);
    assign in_ready   = r_in_ready;
    assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_rgb_block_serializer.sv
// ============================================================================
// Module      : tb_rgb_block_serializer
// Description : Randomized and directed bench for rgb_block_serializer against
//               a queue-of-blocks reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_block_serializer;

    typedef logic [64*24-1:0] blk_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  valid_in = 1'b0;
    logic                  pix_ready = 1'b0;
    logic [7:0][7:0][7:0]  r_in = '0;
    logic [7:0][7:0][7:0]  g_in = '0;
    logic [7:0][7:0][7:0]  b_in = '0;
    logic                  in_ready;
    logic [jpeg_out_pkg::PIX_OUT_W-1:0] pix_out;
    logic                  pix_valid;
    logic [2:0]            pix_row;
    logic [2:0]            pix_col;
    logic                  block_last;
    logic                  overflow;

    rgb_block_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .in_ready   (in_ready),
        .pix_out    (pix_out),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_row    (pix_row),
        .pix_col    (pix_col),
        .block_last (block_last),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Reference model: accepted blocks in arrival order, position in head block.
    blk_t m_q[$];
    int   m_pos    = 0;
    bit   m_active = 1'b0;
    bit   m_ovf    = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        if (obs === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    endtask

    function automatic logic [31:0] ref_out(input logic [23:0] p);
`ifdef SERIALIZER_RGB565_EN
        return {16'd0, p[23:19], p[15:10], p[7:3]};
`else
        return {8'd0, p};
`endif
    endfunction

    function automatic blk_t pattern_blk();
        blk_t b;
        for (int n = 0; n < 64; n++) b[n*24 +: 24] = {8'(n), ~8'(n), 8'h5A};
        return b;
    endfunction

    function automatic blk_t const_blk(input logic [7:0] r);
        blk_t b;
        for (int n = 0; n < 64; n++) b[n*24 +: 24] = {r, 8'(n), 8'(n * 3)};
        return b;
    endfunction

    function automatic blk_t rand_blk();
        blk_t b;
        for (int n = 0; n < 64; n++) b[n*24 +: 24] = 24'($urandom);
        return b;
    endfunction

    task automatic drive_block(input blk_t b);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                r_in[i][j] = b[(i*8+j)*24+16 +: 8];
                g_in[i][j] = b[(i*8+j)*24+8  +: 8];
                b_in[i][j] = b[(i*8+j)*24    +: 8];
            end
        end
    endtask

    task automatic check_outputs();
        blk_t        head;
        logic [23:0] p;
        chk("in_ready", in_ready, m_q.size() < 2);
        chk("overflow", overflow, m_ovf);
        chk("pix_valid", pix_valid, m_active);
        if (m_active && m_q.size() > 0) begin
            head = m_q[0];
            p    = head[m_pos*24 +: 24];
            chk("pix_out", 32'(pix_out), ref_out(p));
            chk("pix_row", pix_row, m_pos / 8);
            chk("pix_col", pix_col, m_pos % 8);
            chk("block_last", block_last, m_pos == 63);
        end else begin
            chk("pix_out_idle", 32'(pix_out), 0);
            chk("block_last_idle", block_last, 0);
        end
    endtask

    // One clock: check present outputs, drive inputs, advance model past the edge.
    task automatic cycle(input bit v, input blk_t b, input bit rdy);
        bit xfer, popping, cap;
        int was;
        @(negedge clk);
        check_outputs();
        valid_in  = v;
        pix_ready = rdy;
        drive_block(b);
        xfer    = m_active && rdy;
        popping = xfer && (m_pos == 63);
        cap     = v && (m_q.size() < 2 || popping);
        if (v && !cap) m_ovf = 1'b1;
        was = m_q.size();
        if (xfer) begin
            if (popping) begin
                void'(m_q.pop_front());
                m_pos = 0;
            end else begin
                m_pos++;
            end
        end
        if (cap) m_q.push_back(b);
        if (m_active) m_active = popping ? (m_q.size() > 0) : 1'b1;
        else          m_active = (was > 0);
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 400 && (m_active || m_q.size() > 0); k++) cycle(1'b0, '0, 1'b1);
        if (k >= 400) chk("drain_timeout", 1, 0);
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_pix_out"}, 32'(pix_out), 0);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_row_col"}, {pix_row, pix_col}, 0);
        chk({tag, "_block_last"}, block_last, 0);
    endtask

    initial begin
        blk_t blk;
        int   k;

        #1 rst = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Single block, sink always ready.
        cycle(1'b1, pattern_blk(), 1'b1);
        drain();

        // Backpressure: ready alternates 1,0,1,0.
        for (int c = 0; c < 140; c++) cycle(c == 0, pattern_blk(), (c % 2) == 0);
        drain();

        // Two blocks back to back.
        cycle(1'b1, const_blk(8'h11), 1'b1);
        cycle(1'b1, const_blk(8'h22), 1'b1);
        drain();

        // Overflow: third block dropped, fourth accepted on the final pop.
        cycle(1'b1, const_blk(8'hA1), 1'b0);
        cycle(1'b1, const_blk(8'hB2), 1'b0);
        cycle(1'b1, const_blk(8'hC3), 1'b0);
        cycle(1'b0, '0, 1'b0);
        for (k = 0; k < 200 && !(m_active && m_pos == 63); k++) cycle(1'b0, '0, 1'b1);
        if (k >= 200) chk("pop_wait_timeout", 1, 0);
        cycle(1'b1, const_blk(8'hD4), 1'b1);
        drain();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) cycle(1'b1, rand_blk(), $urandom_range(0, 9) < 7);
            else                           cycle(1'b0, '0, $urandom_range(0, 9) < 7);
        end
        drain();

        // Asynchronous reset in the middle of a block.
        cycle(1'b1, pattern_blk(), 1'b1);
        for (k = 0; k < 200 && !(m_active && m_pos == 30); k++) cycle(1'b0, '0, 1'b1);
        if (k >= 200) chk("mid_wait_timeout", 1, 0);
        #2 rst = 1'b0;
        valid_in = 1'b0;
        #1 check_reset_values("async_reset");
        m_q.delete();
        m_pos    = 0;
        m_active = 1'b0;
        m_ovf    = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, const_blk(8'h5C), 1'b1);
        drain();

`ifdef SERIALIZER_RGB565_EN
        blk = const_blk(8'h00);
        blk[23:0] = 24'hFF8407;
        cycle(1'b1, blk, 1'b0);
        cycle(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("rgb565_pack", 32'(pix_out), 32'h0000FC20);
        drain();
`else
        blk = const_blk(8'h00);
        blk[23:0] = 24'hFF8407;
        cycle(1'b1, blk, 1'b1);
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
